train_sched: RTL

//  Sequencer that drives the training state machine's handshake inputs. It issues the
//  one-cycle init pulse and counts cycles within each forward/backward pass, raising
//  f_end/b_end at the programmed pass lengths. It walks sample index and epoch and

---
 rtl/train_sched_pkg.sv | 28 ++
 rtl/train_sched_if.sv | 41 ++++
 rtl/train_sched_pass_step_ctr.sv | 29 ++
 rtl/train_sched.sv | 113 +++++++++++
 4 files changed

// File: rtl/train_sched_pkg.sv
// Shared types and width helpers for the training-pass scheduler.
package train_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DONE
  } sched_state_t;

  // Never returns 0, so degenerate sizes still give a legal 1-bit vector.
  function automatic int clog2_min1(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

  function automatic int idx_w(input int n_samples);
    return clog2_min1(n_samples);
  endfunction

  function automatic int step_w(input int f_cycles, input int b_cycles);
    return clog2_min1((f_cycles > b_cycles) ? f_cycles : b_cycles);
  endfunction

  function automatic int ep_w(input int max_epochs);
    return clog2_min1(max_epochs + 1);
  endfunction

endpackage

// File: rtl/train_sched_if.sv
// Handshake bundle between the training FSM side (master) and the scheduler (slave).
interface train_sched_if
  import train_sched_pkg::*;
#(
  parameter int N_SAMPLES  = 4,
  parameter int F_CYCLES   = 4,
  parameter int B_CYCLES   = 6,
  parameter int MAX_EPOCHS = 16
);
  localparam int IDX_W  = idx_w(N_SAMPLES);
  localparam int STEP_W = step_w(F_CYCLES, B_CYCLES);
  localparam int EP_W   = ep_w(MAX_EPOCHS);

  logic              en;
  logic              start;
  logic              f0_pass;
  logic              f1_pass;
  logic              b_pass;
  logic              loss_zero;
  logic              init;
  logic              f_end;
  logic              b_end;
  logic              zero_end_check;
  logic [STEP_W-1:0] step;
  logic [IDX_W-1:0]  sample_idx;
  logic [EP_W-1:0]   epoch;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output en, start, f0_pass, f1_pass, b_pass, loss_zero,
    input  init, f_end, b_end, zero_end_check, step, sample_idx, epoch, busy, done, error
  );

  modport slave (
    input  en, start, f0_pass, f1_pass, b_pass, loss_zero,
    output init, f_end, b_end, zero_end_check, step, sample_idx, epoch, busy, done, error
  );

endinterface

// File: rtl/train_sched_pass_step_ctr.sv
// Cycle counter within one forward/backward pass, with terminal-count flags for both pass kinds.
module train_sched_pass_step_ctr #(
  parameter int STEP_W = 3,
  parameter int F_LAST = 3,
  parameter int B_LAST = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [STEP_W-1:0] count,
  output logic              at_f_last,
  output logic              at_b_last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign at_f_last = (count == STEP_W'(F_LAST));
  assign at_b_last = (count == STEP_W'(B_LAST));

endmodule

// File: rtl/train_sched.sv
// Training sequencer: launches the FSM with an init pulse, times each pass, walks samples/epochs
// and raises the terminate request on convergence or epoch limit.
module train_sched
  import train_sched_pkg::*;
#(
  parameter int N_SAMPLES  = 4,
  parameter int F_CYCLES   = 4,
  parameter int B_CYCLES   = 6,
  parameter int MAX_EPOCHS = 16
) (
  input logic          clk,
  input logic          rst_n,
  train_sched_if.slave bus
);

  localparam int IDX_W  = idx_w(N_SAMPLES);
  localparam int STEP_W = step_w(F_CYCLES, B_CYCLES);
  localparam int EP_W   = ep_w(MAX_EPOCHS);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);
  localparam logic [EP_W-1:0]  EP_LIMIT = EP_W'(MAX_EPOCHS);

  sched_state_t      state;
  logic              init_q;
  logic              error_q;
  logic [IDX_W-1:0]  sample_idx;
  logic [IDX_W-1:0]  zcnt;
  logic [EP_W-1:0]   epoch;
  logic [STEP_W-1:0] step;

  logic fwd, multi, run, at_f_last, at_b_last;
  logic last_f, last_b, term, step_inc, step_clr;

  assign fwd   = bus.f0_pass | bus.f1_pass;
  assign multi = (bus.f0_pass & bus.f1_pass) | (fwd & bus.b_pass);
  assign run   = bus.en && (state == S_RUN);

  // A conflicting pass combination suppresses every pulse for that cycle.
  assign last_f = run && !multi && fwd && at_f_last;
  assign last_b = run && !multi && bus.b_pass && at_b_last;
  assign term   = last_f && bus.f1_pass &&
                  ((bus.loss_zero && (zcnt == LAST_IDX)) || (epoch == EP_LIMIT));

  assign step_clr = run && (multi || last_f || last_b);
  assign step_inc = run && !multi && (fwd || bus.b_pass);

  train_sched_pass_step_ctr #(
    .STEP_W (STEP_W),
    .F_LAST (F_CYCLES - 1),
    .B_LAST (B_CYCLES - 1)
  ) u_step_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (step_inc),
    .clr       (step_clr),
    .count     (step),
    .at_f_last (at_f_last),
    .at_b_last (at_b_last)
  );

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      init_q     <= 1'b0;
      error_q    <= 1'b0;
      sample_idx <= '0;
      zcnt       <= '0;
      epoch      <= '0;
    end else if (bus.en) begin
      init_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            state  <= S_LAUNCH;
            init_q <= 1'b1;
          end
        end
        S_LAUNCH: state <= S_RUN;
        S_RUN: begin
          if (multi) error_q <= 1'b1;
          if (last_b) begin
            if (sample_idx == LAST_IDX) begin
              sample_idx <= '0;
              if (epoch != EP_LIMIT) epoch <= epoch + 1'b1;
            end else begin
              sample_idx <= sample_idx + 1'b1;
            end
          end
          if (last_f) begin
            if (!bus.loss_zero)        zcnt <= '0;
            else if (zcnt != LAST_IDX) zcnt <= zcnt + 1'b1;
          end
          if (term) state <= S_DONE;
        end
        S_DONE: ;
      endcase
    end
  end

  // init_q is held while disabled, so masking keeps the pulse to one enabled cycle.
  assign bus.init           = init_q & bus.en;
  assign bus.f_end          = last_f & ~term;
  assign bus.b_end          = last_b;
  assign bus.zero_end_check = term;
  assign bus.step           = step;
  assign bus.sample_idx     = sample_idx;
  assign bus.epoch          = epoch;
  assign bus.busy           = (state == S_LAUNCH) || (state == S_RUN);
  assign bus.done           = (state == S_DONE);
  assign bus.error          = error_q;

endmodule
